// File: rtl/insn_encoder_if.sv
// insn_encoder_if: request and instruction-memory write bus of insn_encoder
interface insn_encoder_if;
  logic        i_vld;
  logic        o_rdy;
  logic [3:0]  i_class;
  logic [3:0]  i_alu_op;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [31:0] i_imm;
  logic        i_clear;
  logic        o_wr_en;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_err;
  logic        o_full;
  modport master (
    output i_vld, i_class, i_alu_op, i_funct3, i_rd, i_rs1, i_rs2, i_imm, i_clear,
    input  o_rdy, o_wr_en, o_wr_addr, o_wr_data, o_err, o_full
  );
  modport slave (
    input  i_vld, i_class, i_alu_op, i_funct3, i_rd, i_rs1, i_rs2, i_imm, i_clear,
    output o_rdy, o_wr_en, o_wr_addr, o_wr_data, o_err, o_full
  );
endinterface

// File: rtl/insn_encoder.sv
// insn_encoder: encodes requests into RV32I words and writes them sequentially to instruction memory
module insn_encoder #(
  parameter int DEPTH = 2048
) (
  input logic           i_clk,
  input logic           i_reset,
  insn_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ENC, WR} state_t;
  state_t        state_q, state_d;
  logic [3:0]    cls_q, cls_d, op_q, op_d;
  logic [2:0]    f3_q, f3_d;
  logic [4:0]    rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0]   imm_q, imm_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          full_q, full_d, wr_en_q, wr_en_d, err_q, err_d;
  logic [31:0]   wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [2:0]    alu_f3;
  logic [6:0]    f7;
  logic [11:0]   i_imm12;
  logic [31:0]   word;
  logic          legal, rdy;
  assign rdy           = (state_q == IDLE) && !full_q;
  assign bus.o_rdy     = rdy;
  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_wr_data = wr_data_q;
  assign bus.o_err     = err_q;
  assign bus.o_full    = full_q;
  always_comb begin
    case (op_q)
      4'd2:      alu_f3 = 3'd1;
      4'd3:      alu_f3 = 3'd2;
      4'd4:      alu_f3 = 3'd3;
      4'd5:      alu_f3 = 3'd4;
      4'd6, 4'd7: alu_f3 = 3'd5;
      4'd8:      alu_f3 = 3'd6;
      4'd9:      alu_f3 = 3'd7;
      default:   alu_f3 = 3'd0;
    endcase
    f7      = (op_q == 4'd1 || op_q == 4'd7) ? 7'b0100000 : 7'b0000000;
    // shifts carry funct7 in the upper immediate bits, only shamt comes from the request
    i_imm12 = (op_q == 4'd2 || op_q == 4'd6 || op_q == 4'd7) ? {f7, imm_q[4:0]} : imm_q[11:0];
    word    = 32'h0;
    legal   = 1'b0;
    case (cls_q)
      4'd0: begin
        word  = {f7, rs2_q, rs1_q, alu_f3, rd_q, 7'b0110011};
        legal = op_q <= 4'd9;
      end
      4'd1: begin
        word  = {i_imm12, rs1_q, alu_f3, rd_q, 7'b0010011};
        legal = op_q <= 4'd9 && op_q != 4'd1;
      end
      4'd2: begin
        word  = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0000011};
        legal = f3_q != 3'd3 && f3_q <= 3'd5;
      end
      4'd3: begin
        word  = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], 7'b0100011};
        legal = f3_q <= 3'd2;
      end
      4'd4: begin
        word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], 7'b1100011};
        legal = f3_q != 3'd2 && f3_q != 3'd3;
      end
      4'd5: begin
        word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'b1101111};
        legal = 1'b1;
      end
      4'd6: begin
        word  = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b1100111};
        legal = 1'b1;
      end
      4'd7: begin
        word  = {imm_q[31:12], rd_q, 7'b0110111};
        legal = 1'b1;
      end
      4'd8: begin
        word  = {imm_q[31:12], rd_q, 7'b0010111};
        legal = 1'b1;
      end
      default: begin
        word  = 32'h0;
        legal = 1'b0;
      end
    endcase
  end
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    op_d      = op_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    ptr_d     = ptr_q;
    full_d    = full_q;
    wr_en_d   = 1'b0;
    err_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: if (bus.i_vld && rdy) begin
        state_d = ENC;
        cls_d   = bus.i_class;
        op_d    = bus.i_alu_op;
        f3_d    = bus.i_funct3;
        rd_d    = bus.i_rd;
        rs1_d   = bus.i_rs1;
        rs2_d   = bus.i_rs2;
        imm_d   = bus.i_imm;
      end
      ENC: begin
        state_d   = legal ? WR : IDLE;
        wr_en_d   = legal;
        err_d     = !legal;
        wr_addr_d = legal ? 32'({ptr_q, 2'b00}) : wr_addr_q;
        wr_data_d = legal ? word : wr_data_q;
      end
      WR: begin
        state_d = IDLE;
        ptr_d   = ptr_q + AW'(1);
        full_d  = full_q || (&ptr_q);
      end
      default: state_d = IDLE;
    endcase
    if (bus.i_clear) begin
      state_d = IDLE;
      ptr_d   = '0;
      full_d  = 1'b0;
      wr_en_d = 1'b0;
      err_d   = 1'b0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      cls_q     <= '0;
      op_q      <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      ptr_q     <= '0;
      full_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      op_q      <= op_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      ptr_q     <= ptr_d;
      full_q    <= full_d;
      wr_en_q   <= wr_en_d;
      err_q     <= err_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule
